// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
// Module  : int_pkg
// Purpose : Shared constants, state encoding and vector-address helper for
//           the vectored-interrupt scheduler. VEC_BASE_DEF / VEC_STRIDE_DEF
//           must match where the vector stubs are placed in imem.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package int_pkg;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_01F0;  // imem word 124
  localparam logic [31:0] VEC_STRIDE_DEF = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_e;

  // Vector fetch address; unsigned 32-bit wrap, no overflow detection.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [ID_W-1:0] id);
    return base + ({{(32-ID_W){1'b0}}, id} * stride);
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_prio_sel.sv
`default_nettype none
// ============================================================================
// Module  : int_prio_sel
// Purpose : Combinational priority picker. Scans the eligible vector starting
//           at start_i (rotating mode) or at index 0 (fixed mode) and returns
//           the first set index, wrapping from the top index back to 0.
// Ports   : eligible_i  in  per-source eligible requests
//           start_i     in  search start index (used only when rr_en_i = 1)
//           rr_en_i     in  1 = rotating priority, 0 = lowest index wins
//           valid_o     out at least one source eligible
//           id_o        out selected source index
// Rev     : 1.0  initial release
// ============================================================================
module int_prio_sel
  import int_pkg::*;
(
  input  logic [NUM_SRC-1:0] eligible_i,
  input  logic [ID_W-1:0]    start_i,
  input  logic               rr_en_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  logic [ID_W-1:0] base;
  logic [ID_W-1:0] idx;

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    base    = rr_en_i ? start_i : '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // Index arithmetic is ID_W bits wide, so the wrap 3 -> 0 is free.
      idx = base + ID_W'(k);
      if (!valid_o && eligible_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_sched.sv
`default_nettype none
// ============================================================================
// Module  : int_sched
// Purpose : Vectored-interrupt scheduler for the single-cycle core. Detects
//           rising edges on the four peripheral done lines, latches them as
//           pending, masks them, picks one source (fixed or rotating
//           priority), raises irq with the vector address, and holds that
//           source in service until eoi (jepc retired). No nesting.
// Ports   : clk         in  rising-edge clock
//           reset_n     in  asynchronous active-low reset
//           done1..4    in  peripheral completion levels (rise = event)
//           int_ack     in  core accepted the presented interrupt
//           eoi         in  end of current ISR
//           mask_we     in  load mask_d into the enable mask
//           mask_d      in  per-source enable, bit0 = done1
//           ovf_clr     in  clear all overflow flags
//           irq         out interrupt request to core
//           int_addr    out vector fetch address
//           int_id      out selected source index
//           in_service  out ISR active
//           pending     out latched, unserviced events
//           ovf         out sticky overflow per source
// Rev     : 1.0  initial release
// ============================================================================
module int_sched
  import int_pkg::*;
#(
  parameter logic [31:0] VEC_BASE    = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE  = VEC_STRIDE_DEF,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               done1,
  input  logic               done2,
  input  logic               done3,
  input  logic               done4,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_d,
  input  logic               ovf_clr,
  output logic               irq,
  output logic [31:0]        int_addr,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] ovf
);

  int_state_e          state_q, state_d;
  logic                irq_q, irq_d;
  logic [31:0]         int_addr_q, int_addr_d;
  logic [ID_W-1:0]     int_id_q, int_id_d;
  logic                in_service_q, in_service_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  ovf_q, ovf_d;
  logic [NUM_SRC-1:0]  mask_q;
  logic [NUM_SRC-1:0]  done_prev_q;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0]  done_vec;
  logic [NUM_SRC-1:0]  events;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  ack_clr;
  logic                sel_valid;
  logic [ID_W-1:0]     sel_id;

  assign done_vec = {done4, done3, done2, done1};
  assign events   = done_vec & ~done_prev_q;
  assign eligible = pending_q & mask_q;

  int_prio_sel u_sel (
    .eligible_i (eligible),
    .start_i    (rr_ptr_q),
    .rr_en_i    (ROUND_ROBIN),
    .valid_o    (sel_valid),
    .id_o       (sel_id)
  );

  always_comb begin
    state_d      = state_q;
    irq_d        = irq_q;
    int_addr_d   = int_addr_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    rr_ptr_d     = rr_ptr_q;
    ack_clr      = '0;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d    = REQ;
          irq_d      = 1'b1;
          int_id_d   = sel_id;
          int_addr_d = vec_addr(VEC_BASE, VEC_STRIDE, sel_id);
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d           = SERVICE;
          irq_d             = 1'b0;
          in_service_d      = 1'b1;
          ack_clr[int_id_q] = 1'b1;
          rr_ptr_d          = int_id_q + ID_W'(1);
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new edge on the acked source re-pends it; that is a fresh event,
    // not an overflow, so the ack-cleared bit is excluded from ovf.
    pending_d = (pending_q & ~ack_clr) | events;
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (events & pending_q & ~ack_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      int_addr_q   <= VEC_BASE;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
      ovf_q        <= '0;
      mask_q       <= '1;
      done_prev_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      int_addr_q   <= int_addr_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      done_prev_q  <= done_vec;
      rr_ptr_q     <= rr_ptr_d;
      if (mask_we) begin
        mask_q <= mask_d;
      end
    end
  end

  assign irq        = irq_q;
  assign int_addr   = int_addr_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: doc/int_sched.md
Name: int_sched

Overview:
- Vectored-interrupt scheduler between the four peripheral completion lines (done1..done4) and the single-cycle MIPS core.
- Edge-detects and latches requests, applies a mask, and picks one source by fixed or round-robin priority.
- Presents irq plus the vector fetch address to the core's int_ack/intmux path, then holds that source in service until the ISR's jepc retires (eoi).
- Replaces the core's combinational OR of done lines and its vectored_int address lookup.

Parameters:
- VEC_BASE, 32'h0000_01F0, byte address of the vector slot for done1 (imem word 124).
- VEC_STRIDE, 4, byte spacing between vector slots.
- ROUND_ROBIN, 0, 0 = fixed priority (done1 highest, done4 lowest); 1 = rotating priority.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- done1..done4  in  1 each  peripheral completion levels; a rising edge is one event
- int_ack  in  1  core accepts the presented interrupt (pulse)
- eoi  in  1  jepc retired, end of current ISR (pulse)
- mask_we  in  1  load mask_d into mask
- mask_d  in  4  per-source enable, bit0 = done1
- ovf_clr  in  1  clear all overflow flags
- irq  out  1  interrupt request to core
- int_addr  out  32  vector address = VEC_BASE + int_id*VEC_STRIDE
- int_id  out  2  selected source index
- in_service  out  1  ISR active
- pending  out  4  latched, unserviced events
- ovf  out  4  sticky: an edge arrived while that source was already pending

Behaviour:
- Reset values (async, reset_n low): state IDLE; pending 0; ovf 0; mask 4'hF; done-history 0; RR pointer 0; irq 0; int_id 0; int_addr VEC_BASE; in_service 0. Reset mid-ISR abandons it; no vector is retained.
- All outputs are registered.
- Edge detect: event_i = done_i & ~done_prev_i, sampled each clk.
  - pending[i] is set on event_i.
  - If pending[i] is already set, it stays set and ovf[i] is set.
  - ovf_clr clears ovf. If ovf_clr and a new overflow coincide, the set wins.
- Eligible set = pending & mask. Masked sources still latch pending.
- mask_we takes effect the next cycle. It does not affect an id already committed in REQ or SERVICE.
- Selection:
  - Fixed mode: lowest eligible index.
  - RR mode: the search starts at (last serviced id + 1) mod 4 and wraps 3 to 0. The pointer updates on the ack.
- FSM:
  - IDLE: eligible != 0 -> REQ. Latch int_id and int_addr; irq = 1.
  - REQ: irq held high and int_id/int_addr frozen. int_ack -> SERVICE: clear pending[int_id], irq = 0, in_service = 1.
  - SERVICE: eoi -> IDLE, in_service = 0. Arbitration resumes the next cycle.
  - No nesting: new events only pend while in REQ or SERVICE.
- Simultaneous events:
  - An event on int_id in the same cycle as its int_ack leaves pending[int_id] = 1. This is a new event; ovf is not set.
  - eoi in IDLE or REQ is ignored. int_ack in IDLE or SERVICE is ignored.
- Latency:
  - done rise sampled at edge k -> pending at k -> irq high after edge k+1 (2 cycles).
  - eoi at edge m -> earliest next irq after edge m+1.
- Width rules:
  - int_addr = VEC_BASE + {28'b0, int_id, 2'b00} with default stride. Generally int_id*VEC_STRIDE, zero-extended.
  - Unsigned 32-bit, no overflow check.

Decomposition:
- Shared package int_pkg:
  - NUM_SRC = 4, ID_W = 2.
  - State enum {IDLE, REQ, SERVICE}.
  - Default VEC_BASE/VEC_STRIDE constants, shared with imem vector placement.
- One sub-module, int_prio_sel: combinational picker.
  - Inputs: eligible[3:0], start[1:0], rr_en.
  - Outputs: valid, id[1:0].
- All state lives in int_sched.

Test Plan:
- Reset, then done2 rises -> irq high 2 cycles later with int_id = 1, int_addr = 32'h1F4. int_ack -> irq 0, in_service 1, pending 4'b0000. eoi -> in_service 0.
- done1 and done4 rise in the same cycle, fixed mode -> first int_addr = 32'h1F0. After ack and eoi, the second request has int_addr = 32'h1FC.
- ROUND_ROBIN = 1, all four sources held pending -> service order 0,1,2,3,0. Each pending bit re-asserted by a fresh edge after its clear.
- mask_d = 4'b1110, done1 rises -> pending = 4'b0001 and irq stays 0. mask_we with 4'hF -> irq follows the next cycle with int_addr 32'h1F0.
- done3 pulses twice before ack -> ovf = 4'b0100 and pending[2] = 1. ovf_clr -> ovf = 0. A done3 edge coincident with int_ack -> pending[2] stays 1 after the ack.
- reset_n dropped while in SERVICE -> all outputs return to reset values immediately (async). eoi and int_ack arriving after release are ignored.
